// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-only memory accesses,
// using read-modify-write for sub-word stores and extending load data.
module load_store_unit #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] writedata,
    output logic        memwrite,
    output logic        memread,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {IDLE, READ, LATCH, WRITE, RESP} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        uns_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wdata_reg;

    logic        req_err;
    logic [31:0] merged_word;
    logic [31:0] load_ext;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign req_ready = (state_reg == IDLE);
    assign memread   = (state_reg == READ);
    assign memwrite  = (state_reg == WRITE);

    assign req_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    // Per-lane merge: a lane takes store data when the access covers it,
    // otherwise it keeps what memory returned.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic lane_hit;
            always_comb begin
                case (size_reg)
                    2'b00:   lane_hit = (lane_reg == 2'(gi));
                    2'b01:   lane_hit = (lane_reg[1] == 1'(gi >> 1));
                    default: lane_hit = 1'b1;
                endcase
            end
            assign merged_word[8*gi +: 8] = !lane_hit ? readdata[8*gi +: 8] :
                                            (size_reg == 2'b01 && (gi % 2) == 1) ?
                                            wdata_reg[15:8] : wdata_reg[7:0];
        end
    endgenerate

    always_comb begin
        lane_byte = readdata[8*lane_reg +: 8];
        lane_half = lane_reg[1] ? readdata[31:16] : readdata[15:0];
        case (size_reg)
            2'b00:   load_ext = {{24{~uns_reg & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{16{~uns_reg & lane_half[15]}}, lane_half};
            default: load_ext = readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            size_reg   <= 2'b00;
            uns_reg    <= 1'b0;
            lane_reg   <= 2'b00;
            wdata_reg  <= 16'h0;
            address    <= 32'h0;
            writedata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg     <= req_we;
                        size_reg   <= req_size;
                        uns_reg    <= req_unsigned;
                        lane_reg   <= req_addr[1:0];
                        wdata_reg  <= req_wdata[15:0];
                        address    <= {req_addr[31:2], 2'b00};
                        resp_rdata <= 32'h0;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state_reg  <= RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            writedata <= req_wdata;
                            state_reg <= WRITE;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: state_reg <= LATCH;
                LATCH: begin
                    if (we_reg) begin
                        writedata <= merged_word;
                        state_reg <= WRITE;
                    end else begin
                        resp_rdata <= load_ext;
                        resp_valid <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-addressed memory model, directed scenarios and
// randomized requests checked against an arithmetic reference of memory contents.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] writedata;
    logic        memwrite;
    logic        memread;
    logic [31:0] readdata;

    logic [31:0] dm [256];
    logic [31:0] ref_mem [256];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .address(address), .writedata(writedata),
        .memwrite(memwrite), .memread(memread), .readdata(readdata)
    );

    // Data memory: registered read, write on the WRITE-state edge.
    always @(posedge clk) begin
        if (memwrite) dm[address[9:2]] <= writedata;
        if (memread)  readdata <= dm[address[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0] == 1'b1) ||
               (size == 2'd2 && addr[1:0] != 2'd0) || (addr / 4 >= 256);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        logic [31:0] w, v;
        int k;
        w = ref_mem[addr[9:2]];
        v = w;
        if (size == 2'd0) begin
            k = int'(addr % 4);
            v = (w >> (8 * k)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 2'd1) begin
            k = int'((addr % 4) / 2) * 2;
            v = (w >> (8 * k)) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [1:0] size, input logic [31:0] addr,
                                              input logic [31:0] wdata);
        logic [31:0] w;
        int k;
        w = ref_mem[addr[9:2]];
        if (size == 2'd0) begin
            k = int'(addr % 4);
            w = (w & ~(32'hFF << (8 * k))) | ((wdata & 32'hFF) << (8 * k));
        end else if (size == 2'd1) begin
            k = int'((addr % 4) / 2) * 2;
            w = (w & ~(32'hFFFF << (8 * k))) | ((wdata & 32'hFFFF) << (8 * k));
        end else begin
            w = wdata;
        end
        return w;
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rdata);
        logic        exp_err, got_err, done;
        logic [31:0] exp_rdata, exp_word, got_word, got_addr;
        int          exp_lat, exp_rd, exp_wr, lat, rd_cyc, wr_cyc, rd_cnt, wr_cnt;
        exp_err   = ref_err(size, addr);
        exp_lat   = exp_err ? 1 : (!we ? 3 : (size == 2'd2 ? 2 : 4));
        exp_rd    = (exp_err || (we && size == 2'd2)) ? 0 : 1;
        exp_wr    = (exp_err || !we) ? 0 : (size == 2'd2 ? 1 : 3);
        exp_rdata = (exp_err || we) ? 32'h0 : ref_load(size, uns, addr);
        exp_word  = ref_merge(size, addr, wdata);
        got_rdata = 32'h0; got_err = 1'b0; got_word = 32'h0; got_addr = 32'h0;
        lat = 0; rd_cyc = 0; wr_cyc = 0; rd_cnt = 0; wr_cnt = 0; done = 1'b0;

        @(negedge clk);
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8 && !done; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (memread) begin rd_cnt++; rd_cyc = c; got_addr = address; end
            if (memwrite) begin wr_cnt++; wr_cyc = c; got_word = writedata; end
            if (resp_valid) begin
                done = 1'b1; lat = c; got_rdata = resp_rdata; got_err = resp_err;
            end
        end
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "/err"}, 32'(got_err), 32'(exp_err));
        check({tag, "/rdata"}, got_rdata, exp_rdata);
        check({tag, "/rd_cyc"}, 32'(rd_cyc), 32'(exp_rd));
        check({tag, "/wr_cyc"}, 32'(wr_cyc), 32'(exp_wr));
        check({tag, "/pulses"}, 32'(rd_cnt + wr_cnt), 32'((exp_rd != 0 ? 1 : 0) + (exp_wr != 0 ? 1 : 0)));
        if (exp_rd != 0) check({tag, "/addr"}, got_addr, {addr[31:2], 2'b00});
        if (exp_wr != 0) check({tag, "/wword"}, got_word, exp_word);
        if (we && !exp_err) ref_mem[addr[9:2]] = exp_word;
        $display("[TB] txn %s we=%0d size=%0d uns=%0d addr=%08h wdata=%08h rdata=%08h err=%0d lat=%0d",
                 tag, we, size, uns, addr, wdata, got_rdata, got_err, lat);
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] q_addr [3];
        int idx, pulses, reads;

        for (int i = 0; i < 256; i++) begin
            dm[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/memread", 32'(memread), 32'd0);
        check("rst/memwrite", 32'(memwrite), 32'd0);
        check("rst/address", address, 32'h0);
        check("rst/writedata", writedata, 32'h0);
        check("rst/resp_valid", 32'(resp_valid), 32'd0);
        check("rst/resp_rdata", resp_rdata, 32'h0);
        check("rst/resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst/ready", 32'(req_ready), 32'd1);

        // Reset during WRITE of a byte store: memory must be untouched.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h14; req_wdata = 32'hFF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        idx = 0;
        for (int c = 1; c <= 8 && !memwrite; c++) begin
            @(posedge clk);
            #1 idx = c + 1;
        end
        check("abort/wr_cyc", 32'(idx), 32'd3);
        #1 reset = 1'b1;
        #1 check("abort/memwrite_drop", 32'(memwrite), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("abort/no_resp", 32'(pulses), 32'd0);
        @(posedge clk);
        do_req("abort_lw", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r);
        check("abort/lw14", r, 32'h00000005);

        do_req("t1_lw", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r);
        check("t1/lw14", r, 32'h00000005);
        do_req("t2_sb", 1'b1, 2'd0, 1'b0, 32'h15, 32'hAB, r);
        do_req("t2_lw", 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r);
        check("t2/lw14", r, 32'h0000AB05);
        do_req("t3_sh", 1'b1, 2'd1, 1'b0, 32'h1A, 32'h8001, r);
        do_req("t3_lh", 1'b0, 2'd1, 1'b0, 32'h1A, 32'h0, r);
        check("t3/lh", r, 32'hFFFF8001);
        do_req("t3_lhu", 1'b0, 2'd1, 1'b1, 32'h1A, 32'h0, r);
        check("t3/lhu", r, 32'h00008001);
        do_req("t3_lw", 1'b0, 2'd2, 1'b1, 32'h18, 32'h0, r);
        check("t3/lw", r, 32'h80010006);
        do_req("t3_lb", 1'b0, 2'd0, 1'b0, 32'h1B, 32'h0, r);
        check("t3/lb", r, 32'hFFFFFF80);
        do_req("t4_lw_mis", 1'b0, 2'd2, 1'b0, 32'h16, 32'h0, r);
        do_req("t4_lh_mis", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, r);
        do_req("t4_size3", 1'b1, 2'd3, 1'b0, 32'h20, 32'h1234, r);
        do_req("t4_range", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, r);
        do_req("t4_sw_range", 1'b1, 2'd2, 1'b0, 32'h3FC, 32'hCAFEF00D, r);
        do_req("t4_lw_last", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, r);
        check("t4/lw_last", r, 32'hCAFEF00D);

        // req_valid held high across three loads: each accepted exactly once.
        q_addr[0] = 32'h20; q_addr[1] = 32'h24; q_addr[2] = 32'h28;
        idx = 0; pulses = 0; reads = 0;
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) begin
                check("t6/rdata", resp_rdata, ref_load(2'd2, 1'b0, q_addr[pulses % 3]));
                pulses++;
            end
            if (memread) reads++;
            req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
            req_valid = (idx < 3);
            if (idx < 3) req_addr = q_addr[idx];
            if (req_valid && req_ready) idx++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("t6/resp_pulses", 32'(pulses), 32'd3);
        check("t6/memreads", 32'(reads), 32'd3);
        @(posedge clk);

        for (int n = 0; n < 250; n++) begin
            logic        we, uns;
            logic [1:0]  size;
            logic [31:0] addr, wdata;
            int          sel;
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            sel   = int'($urandom_range(0, 15));
            size  = (sel == 0) ? 2'd3 : 2'(sel % 3);
            addr  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd2) addr[1:0] = 2'b00;
                if (size == 2'd1) addr[0] = 1'b0;
            end
            wdata = $urandom;
            do_req($sformatf("rnd%0d", n), we, size, uns, addr, wdata, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
